pll_lock_supervisor: RTL and testbench

Supervises an iCE40 PLL from the free-running board oscillator domain. Drives the PLL's active-low RESETB and consumes its LOCK output. Issues a clean downstream reset only after lock has been stable for a qualified period. Retries the PLL on lock timeout and counts loss-of-lock events.

---
 rtl/pll_lock_supervisor.sv | 140 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// Sequences an iCE40 PLL from the board-oscillator domain: pulses RESETB, waits for a
// qualified lock, then releases downstream reset. Retries on timeout and counts lock losses.
module pll_lock_supervisor #(
  parameter int unsigned RESET_HOLD    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             locked,
  input  logic             retry,
  output logic             pll_resetb,
  output logic             sys_resetn,
  output logic             lock_ok,
  output logic             fault,
  output logic [CNT_W-1:0] relock_count
);

  localparam int unsigned TMax0  = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int unsigned TMax   = (TMax0 > RESET_HOLD) ? TMax0 : RESET_HOLD;
  localparam int unsigned TimerW = $clog2(TMax + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {StPllRst, StWaitLock, StStable, StRun, StFault} state_e;

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [RetryW-1:0]  retries_q, retries_d;
  logic [CNT_W-1:0]   relock_q, relock_d;
  logic [1:0]         sync_q;
  logic               locked_s;

  // locked comes straight from the PLL and is asynchronous to clk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], locked};
    end
  end

  assign locked_s = sync_q[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StPllRst;
      timer_q   <= '0;
      retries_q <= '0;
      relock_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retries_q <= retries_d;
      relock_q  <= relock_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retries_d = retries_q;
    relock_d  = relock_q;
    case (state_q)
      StPllRst: begin
        if (timer_q == TimerW'(RESET_HOLD - 1)) begin
          state_d = StWaitLock;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitLock: begin
        // Lock takes priority over a timeout landing in the same cycle.
        if (locked_s) begin
          state_d = StStable;
          timer_d = '0;
        end else if (timer_q == TimerW'(LOCK_TIMEOUT - 1)) begin
          retries_d = retries_q + 1'b1;
          timer_d   = '0;
          state_d   = (retries_q == RetryW'(MAX_RETRIES - 1)) ? StFault : StPllRst;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StStable: begin
        // A glitch in lock restarts qualification without costing a retry.
        if (!locked_s) begin
          state_d = StWaitLock;
          timer_d = '0;
        end else if (timer_q == TimerW'(STABLE_CYCLES - 1)) begin
          state_d   = StRun;
          timer_d   = '0;
          retries_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d = StPllRst;
          timer_d = '0;
          if (relock_q != '1) begin
            relock_d = relock_q + 1'b1;
          end
        end
      end
      StFault: begin
        if (retry) begin
          state_d   = StPllRst;
          timer_d   = '0;
          retries_d = '0;
        end
      end
      default: begin
        state_d = StPllRst;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pll_resetb <= 1'b0;
      sys_resetn <= 1'b0;
      lock_ok    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      pll_resetb <= !((state_d == StPllRst) || (state_d == StFault));
      sys_resetn <= (state_d == StRun);
      lock_ok    <= (state_d == StRun);
      fault      <= (state_d == StFault);
    end
  end

  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor; edges counted from resetn release or stimulus change.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       resetn;
  logic       locked;
  logic       retry;
  logic       pll_resetb;
  logic       sys_resetn;
  logic       lock_ok;
  logic       fault;
  logic [7:0] relock_count;

  int tests = 0;
  int failures = 0;

  pll_lock_supervisor #(
    .RESET_HOLD   (4),
    .LOCK_TIMEOUT (16),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (3),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .locked      (locked),
    .retry       (retry),
    .pll_resetb  (pll_resetb),
    .sys_resetn  (sys_resetn),
    .lock_ok     (lock_ok),
    .fault       (fault),
    .relock_count(relock_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic steps(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b1;
    locked = 1'b0;
    retry  = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("rst_pll_resetb", pll_resetb, 0);
    check("rst_sys_resetn", sys_resetn, 0);
    check("rst_lock_ok", lock_ok, 0);
    check("rst_fault", fault, 0);
    check("rst_relock", relock_count, 0);
    steps(2);
    resetn = 1'b1;

    // Power-up: 4-cycle PLL reset, lock from cycle 10, RUN 11 edges after lock sampled.
    steps(3);
    check("t1_pll_low_e3", pll_resetb, 0);
    steps(1);
    check("t1_pll_high_e4", pll_resetb, 1);
    steps(6);
    locked = 1'b1;
    steps(10);
    check("t1_sys_e10", sys_resetn, 0);
    steps(1);
    check("t1_sys_e11", sys_resetn, 1);
    check("t1_lock_ok_e11", lock_ok, 1);
    check("t1_fault", fault, 0);
    check("t1_relock", relock_count, 0);
    check("t1_pll", pll_resetb, 1);

    // One-cycle loss in RUN.
    locked = 1'b0;
    steps(1);
    locked = 1'b1;
    steps(1);
    check("t4_sys_e2", sys_resetn, 1);
    steps(1);
    check("t4_sys_e3", sys_resetn, 0);
    check("t4_lock_ok_e3", lock_ok, 0);
    check("t4_pll_e3", pll_resetb, 0);
    check("t4_relock_1", relock_count, 1);
    steps(3);
    check("t4_pll_e6", pll_resetb, 0);
    steps(1);
    check("t4_pll_e7", pll_resetb, 1);
    steps(8);
    check("t4_sys_e15", sys_resetn, 0);
    steps(1);
    check("t4_sys_e16", sys_resetn, 1);
    repeat (299) begin
      locked = 1'b0;
      steps(1);
      locked = 1'b1;
      steps(15);
    end
    check("t4_relock_sat", relock_count, 255);
    check("t4_sys_after_loop", sys_resetn, 1);

    // Asynchronous reset in RUN, then in STABLE.
    resetn = 1'b0;
    #1;
    check("t5_run_sys", sys_resetn, 0);
    check("t5_run_lock_ok", lock_ok, 0);
    check("t5_run_relock", relock_count, 0);
    check("t5_run_pll", pll_resetb, 0);
    check("t5_run_fault", fault, 0);
    steps(1);
    resetn = 1'b1;
    steps(7);
    check("t5_stable_pll_pre", pll_resetb, 1);
    check("t5_stable_sys_pre", sys_resetn, 0);
    resetn = 1'b0;
    #1;
    check("t5_stable_pll", pll_resetb, 0);
    check("t5_stable_sys", sys_resetn, 0);
    steps(1);
    resetn = 1'b1;

    // Loss lands on the STABLE expiry edge (E13); then retry outside FAULT.
    steps(10);
    locked = 1'b0;
    steps(3);
    check("t6_sys_e13", sys_resetn, 0);
    check("t6_lock_ok_e13", lock_ok, 0);
    check("t6_pll_e13", pll_resetb, 1);
    retry = 1'b1;
    steps(1);
    retry = 1'b0;
    check("t6_retry_pll", pll_resetb, 1);
    check("t6_retry_fault", fault, 0);
    locked = 1'b1;
    steps(10);
    check("t6_sys_e10", sys_resetn, 0);
    steps(1);
    check("t6_sys_e11", sys_resetn, 1);

    // Three-cycle dropout mid-STABLE.
    resetn = 1'b0;
    #1;
    steps(1);
    resetn = 1'b1;
    steps(6);
    locked = 1'b0;
    steps(3);
    check("t3_pll_e9", pll_resetb, 1);
    check("t3_sys_e9", sys_resetn, 0);
    locked = 1'b1;
    steps(10);
    check("t3_sys_e19", sys_resetn, 0);
    steps(1);
    check("t3_sys_e20", sys_resetn, 1);
    check("t3_fault", fault, 0);

    // Never locks: three timeouts into FAULT, then retry.
    resetn = 1'b0;
    locked = 1'b0;
    #1;
    steps(1);
    resetn = 1'b1;
    steps(3);
    check("t2_p1_low", pll_resetb, 0);
    steps(1);
    check("t2_p1_high", pll_resetb, 1);
    steps(15);
    check("t2_wait1_e19", pll_resetb, 1);
    steps(1);
    check("t2_p2_start", pll_resetb, 0);
    steps(3);
    check("t2_p2_low", pll_resetb, 0);
    steps(1);
    check("t2_p2_high", pll_resetb, 1);
    steps(16);
    check("t2_p3_start", pll_resetb, 0);
    steps(4);
    check("t2_p3_high", pll_resetb, 1);
    steps(15);
    check("t2_e59_fault", fault, 0);
    check("t2_e59_pll", pll_resetb, 1);
    steps(1);
    check("t2_e60_fault", fault, 1);
    check("t2_e60_pll", pll_resetb, 0);
    check("t2_e60_sys", sys_resetn, 0);
    steps(10);
    check("t2_fault_sticky", fault, 1);
    check("t2_pll_held", pll_resetb, 0);
    retry = 1'b1;
    steps(1);
    retry = 1'b0;
    check("t2_retry_fault", fault, 0);
    check("t2_retry_pll", pll_resetb, 0);
    steps(3);
    check("t2_retry_pll_e3", pll_resetb, 0);
    steps(1);
    check("t2_retry_pll_e4", pll_resetb, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
